pdm_multi_recorder: RTL and testbench
=====================================

Name: pdm_multi_recorder

Overview:
- Parametrised capture engine for the speech-recognition front end. Generates the PDM microphone clock and samples the 1-bit mic stream.
- Packs samples into RAM words, or optionally converts them to per-word pulse-density counts. Writes a fixed-length recording into one of NUM_SLOTS sample RAMs (live buffer plus up/down/left/right templates).
- Sits between the mic pins and the sample RAM bank. Feeds PDM_control and the template comparison logic.

Parameters:
- WORD_W, 32: bits per RAM word; also the number of mic samples per word.
- ADDR_W, 12: RAM address width.
- DEPTH, 4096: words per recording; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- CLK_DIV, 42: clk cycles per micClk period; must be even and >= 4.
- NUM_SLOTS, 5: number of destination RAMs. SLOT_W = clog2(NUM_SLOTS), minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a recording.
- abort  in  1  one-cycle request to cancel the current recording.
- slot  in  SLOT_W  destination RAM index; sampled with start.
- mode  in  1  0 = raw bit packing, 1 = density count; sampled with start.
- micData  in  1  PDM data from the microphone.
- micClk  out  1  PDM clock to the microphone.
- ram_wr  out  1  write strobe, common to all slots.
- slot_we  out  NUM_SLOTS  one-hot write enable for the latched slot (ram_wr AND decoded slot).
- ram_addr  out  ADDR_W  shared RAM address.
- ram_data  out  WORD_W  word to write.
- busy  out  1  high while a recording is in progress.
- done  out  1  one-cycle pulse when a recording completes.
- aborted  out  1  one-cycle pulse when a recording is cancelled.

Behaviour:
- Reset values: all outputs 0; state IDLE; divider count = 0; shift register, bit counter and ones counter = 0.
- Divider:
  - Free-runs from reset, independent of state. Count runs 0..CLK_DIV-1 and wraps.
  - micClk = 1 when count >= CLK_DIV/2 (registered compare).
  - Sample strobe is the cycle in which count == CLK_DIV-1; micData is captured in that cycle.
- States are IDLE, CAPTURE, WRITE and DONE. All outputs are registered or decoded from the state register.
- IDLE:
  - Leaves only on start=1 with slot < NUM_SLOTS.
  - On that transition it latches slot and mode and clears addr, bit counter, shift register and ones counter, then moves to CAPTURE.
  - start with slot >= NUM_SLOTS is ignored: no state change, no pulse.
- CAPTURE:
  - On each strobe, raw mode shifts MSB-first: shreg <= {shreg[WORD_W-2:0], micData}. Density mode does ones += micData.
  - Every strobe increments the bit counter.
  - The strobe that brings the bit counter to WORD_W moves the FSM to WRITE. That strobe's bit is included in the word.
- WRITE (exactly one cycle):
  - ram_wr=1 and slot_we[slot]=1.
  - ram_data = shreg in raw mode; in density mode, ones zero-extended to WORD_W (range 0..WORD_W).
  - ram_addr = current word index.
  - Next cycle: if addr == DEPTH-1, go to DONE with addr held. Otherwise addr+1, clear counters, return to CAPTURE.
  - The first word is written 1 + WORD_W*CLK_DIV cycles after the first strobe following start, at most.
- DONE (one cycle): done=1, then IDLE. ram_addr holds DEPTH-1 until the next start.
- busy = 1 in CAPTURE and WRITE.
- start while busy is ignored, and so are slot and mode changes while busy.
- abort:
  - In CAPTURE: go to IDLE next cycle, aborted=1 for one cycle, partial word discarded, no write.
  - In WRITE: the write in that cycle still completes, then IDLE with aborted=1. done never pulses for an aborted recording.
  - In IDLE or DONE: abort is ignored.
- start and abort in the same cycle from IDLE: start wins and abort is ignored.
- Strobe coincident with the WRITE cycle cannot occur, because CLK_DIV >= 4 and the WRITE follows a strobe.
- rst mid-recording: immediate return to reset values. The RAM keeps any words already written.

Test Plan:
- WORD_W=8, DEPTH=4, CLK_DIV=4, NUM_SLOTS=5. micClk pattern after reset: 0,0,1,1 repeating. Strobe when count=3.
- Raw capture, slot=2, mode=0, micData pattern 1,0,1,1,0,0,1,0 repeated -> 4 writes, each ram_data=8'hB2. Addresses 0,1,2,3. slot_we=5'b00100 on each write. done pulses once 1 cycle after the last write. busy drops together with done going high.
- Density, mode=0→1, micData held 1 for word 0 and 0 for word 1 -> ram_data 8'd8 then 8'd0. Alternating 1,0 input -> 8'd4.
- abort 3 strobes into word 2 -> exactly 2 writes (addr 0,1). aborted=1 for one cycle, done never asserted, busy=0 next cycle.
- start with slot=5 -> no busy and no writes. start pulsed while busy with slot=1 -> latched slot unchanged, write count still 4.
- rst asserted mid-WRITE -> ram_wr, slot_we and busy are 0 immediately. A fresh start then records 4 words from addr 0.

Source files
------------

// File: rtl/pdm_multi_recorder.sv
// PDM microphone capture engine: free-running micClk divider, per-word bit packing or
// pulse-density counting, and fixed-length recording into one of NUM_SLOTS sample RAMs.
module pdm_multi_recorder #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int CLK_DIV   = 42,
    parameter int NUM_SLOTS = 5,
    localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SLOT_W-1:0]    slot,
    input  logic                 mode,
    input  logic                 micData,
    output logic                 micClk,
    output logic                 ram_wr,
    output logic [NUM_SLOTS-1:0] slot_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [WORD_W-1:0]    ram_data,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               mic_clk_q;
    logic               strobe;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               mode_q, mode_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0]   ones_q, ones_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic               aborted_q, aborted_d;
    logic               slot_ok;

    // Divider free-runs regardless of FSM state; micClk is the registered half-period compare.
    assign strobe = (div_q == DIV_LAST);
    assign div_d  = strobe ? '0 : div_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            mic_clk_q <= (div_d >= DIV_HALF);
        end
    end

    assign slot_ok = ({1'b0, slot} < (SLOT_W + 1)'(NUM_SLOTS));

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        bitcnt_d  = bitcnt_q;
        ones_d    = ones_q;
        shreg_d   = shreg_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && slot_ok) begin
                    slot_d   = slot;
                    mode_d   = mode;
                    addr_d   = '0;
                    bitcnt_d = '0;
                    ones_d   = '0;
                    shreg_d  = '0;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (strobe) begin
                    if (mode_q) begin
                        ones_d = ones_q + CNT_W'(micData);
                    end else begin
                        shreg_d = {shreg_q[WORD_W-2:0], micData};
                    end
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // An abort here still lets this cycle's write land; only the follow-on is cancelled.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (addr_q == ADDR_LAST) begin
                    state_d = S_DONE;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    bitcnt_d = '0;
                    ones_d   = '0;
                    shreg_d  = '0;
                    state_d  = S_CAPTURE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            bitcnt_q  <= '0;
            ones_q    <= '0;
            shreg_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            bitcnt_q  <= bitcnt_d;
            ones_q    <= ones_d;
            shreg_q   <= shreg_d;
            aborted_q <= aborted_d;
        end
    end

    assign micClk   = mic_clk_q;
    assign ram_wr   = (state_q == S_WRITE);
    assign slot_we  = ram_wr ? (NUM_SLOTS'(1) << slot_q) : '0;
    assign ram_addr = addr_q;
    assign ram_data = ram_wr ? (mode_q ? WORD_W'(ones_q) : shreg_q) : '0;
    assign busy     = (state_q == S_CAPTURE) || (state_q == S_WRITE);
    assign done     = (state_q == S_DONE);
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_pdm_multi_recorder.sv
// Randomized and directed bench for pdm_multi_recorder against a queue-based recording model.
module tb_pdm_multi_recorder;

    localparam int WORD_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int DEPTH     = 4;
    localparam int CLK_DIV   = 4;
    localparam int NUM_SLOTS = 5;
    localparam int SLOT_W    = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [SLOT_W-1:0]    slot = '0;
    logic                 mode = 1'b0;
    logic                 micData = 1'b0;
    logic                 micClk;
    logic                 ram_wr;
    logic [NUM_SLOTS-1:0] slot_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [WORD_W-1:0]    ram_data;
    logic                 busy;
    logic                 done;
    logic                 aborted;

    pdm_multi_recorder #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .CLK_DIV(CLK_DIV), .NUM_SLOTS(NUM_SLOTS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .slot(slot), .mode(mode),
        .micData(micData), .micClk(micClk), .ram_wr(ram_wr), .slot_we(slot_we),
        .ram_addr(ram_addr), .ram_data(ram_data), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a recording is a sequence of WORD_W-bit groups taken one bit per
    // CLK_DIV clocks; each full group is written one cycle later at the running word index.
    int        m_div = 0;
    bit        m_clk = 0;
    bit        m_active = 0;
    bit        m_wr = 0;
    bit        m_done = 0;
    bit        m_abt = 0;
    int        m_addr = 0;
    int        m_slot = 0;
    bit        m_mode = 0;
    bit        m_bits[$];
    int        cap_total = 0;
    bit        m_strobe, new_done, new_abt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div = 0; m_clk = 0; m_active = 0; m_wr = 0; m_done = 0; m_abt = 0;
            m_addr = 0; m_slot = 0; m_mode = 0; m_bits.delete(); cap_total = 0;
        end else begin
            m_strobe = (m_div == CLK_DIV - 1);
            new_done = 0;
            new_abt  = 0;
            if (m_wr) begin
                m_wr = 0;
                m_bits.delete();
                if (abort) begin
                    m_active = 0; new_abt = 1;
                end else if (m_addr == DEPTH - 1) begin
                    m_active = 0; new_done = 1;
                end else begin
                    m_addr++;
                end
            end else if (m_active) begin
                if (abort) begin
                    m_active = 0; new_abt = 1; m_bits.delete();
                end else if (m_strobe) begin
                    m_bits.push_back(micData);
                    cap_total++;
                    if (m_bits.size() == WORD_W) m_wr = 1;
                end
            end else if (!m_done && start && int'(slot) < NUM_SLOTS) begin
                m_active = 1; m_slot = int'(slot); m_mode = mode; m_addr = 0;
                m_bits.delete(); cap_total = 0;
            end
            m_done = new_done;
            m_abt  = new_abt;
            m_div  = (m_div + 1) % CLK_DIV;
            m_clk  = (m_div >= CLK_DIV / 2);
        end
    end

    function automatic logic [31:0] exp_word();
        logic [31:0] w = 0;
        foreach (m_bits[i]) begin
            if (m_mode) w = w + 32'(m_bits[i]);
            else        w = {w[30:0], m_bits[i]};
        end
        return w;
    endfunction

    // Compare process and write/pulse log, sampled on the falling edge.
    int          cyc = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] wr_we[$];
    int          done_cnt = 0, abt_cnt = 0, busy_cnt = 0;
    int          last_wr_cyc = 0, done_cyc = 0;
    logic        busy_at_done = 1'b0;

    always @(negedge clk) begin
        cyc++;
        chk("micClk", micClk, m_clk);
        chk("ram_wr", ram_wr, m_wr);
        chk("slot_we", slot_we, m_wr ? (32'd1 << m_slot) : 32'd0);
        chk("ram_addr", ram_addr, m_addr);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("aborted", aborted, m_abt);
        if (m_wr) chk("ram_data", ram_data, exp_word());
        if (ram_wr) begin
            wr_addr.push_back(32'(ram_addr));
            wr_data.push_back(32'(ram_data));
            wr_we.push_back(32'(slot_we));
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++; done_cyc = cyc; busy_at_done = busy;
        end
        if (aborted) abt_cnt++;
        if (busy) busy_cnt++;
    end

    // micData driver: a repeating pattern indexed by captured-bit count, or random bits.
    bit          mic_mode = 0;
    logic [15:0] pat_bits = '0;
    int          pat_len = 8;

    always @(posedge clk) begin
        #2;
        if (mic_mode) micData = pat_bits[pat_len - 1 - (cap_total % pat_len)];
        else          micData = 1'($urandom);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_we.delete();
        done_cnt = 0; abt_cnt = 0; busy_cnt = 0;
    endtask

    task automatic pulse_start(input int s, input bit md);
        start = 1'b1; slot = SLOT_W'(s); mode = md;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_words(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] we);
        logic [31:0] expd[4];
        expd = '{d0, d1, d2, d3};
        chk({tag, "_nwr"}, wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD, i);
            chk({tag, "_data"}, (i < wr_data.size()) ? wr_data[i] : 32'hDEAD, expd[i]);
            chk({tag, "_we"},   (i < wr_we.size())   ? wr_we[i]   : 32'hDEAD, we);
        end
    endtask

    initial begin
        logic [3:0] clk_pat;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_slot_we", slot_we, 0);
        clk_pat = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("micclk_pattern", micClk, clk_pat[3 - (i % 4)]);
        end
        step();

        // Raw packing: 1,0,1,1,0,0,1,0 -> 8'hB2 in every word of slot 2.
        mic_mode = 1; pat_bits = 16'h00B2; pat_len = 8;
        clear_log();
        pulse_start(2, 0);
        wait_idle("raw", 1000);
        step(2);
        check_words("raw", 32'hB2, 32'hB2, 32'hB2, 32'hB2, 32'b00100);
        chk("raw_done_cnt", done_cnt, 1);
        chk("raw_done_lat", done_cyc - last_wr_cyc, 1);
        chk("raw_busy_at_done", busy_at_done, 0);
        chk("raw_addr_hold", ram_addr, DEPTH - 1);

        // Density: eight ones then eight zeros, then alternating bits.
        pat_bits = 16'hFF00; pat_len = 16;
        clear_log();
        pulse_start(0, 1);
        wait_idle("dens", 1000);
        step(2);
        check_words("dens", 8, 0, 8, 0, 32'b00001);
        pat_bits = 16'h00AA; pat_len = 8;
        clear_log();
        pulse_start(3, 1);
        wait_idle("alt", 1000);
        step(2);
        check_words("alt", 4, 4, 4, 4, 32'b01000);

        // Abort three strobes into word 2.
        mic_mode = 0;
        clear_log();
        pulse_start(3, 0);
        n = 0;
        while (cap_total != 2 * WORD_W + 3 && n < 1000) begin
            step();
            n++;
        end
        chk("abort_wait_timeout", 32'(n < 1000), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy_next", busy, 0);
        chk("abort_pulse", aborted, 1);
        step();
        chk("abort_pulse_end", aborted, 0);
        step(20);
        chk("abort_nwr", wr_addr.size(), 2);
        chk("abort_addr0", (wr_addr.size() > 0) ? wr_addr[0] : 32'hDEAD, 0);
        chk("abort_addr1", (wr_addr.size() > 1) ? wr_addr[1] : 32'hDEAD, 1);
        chk("abort_cnt", abt_cnt, 1);
        chk("abort_no_done", done_cnt, 0);

        // Out-of-range slot is ignored.
        clear_log();
        pulse_start(5, 0);
        step(10);
        chk("badslot_busy", busy_cnt, 0);
        chk("badslot_nwr", wr_addr.size(), 0);

        // Start while busy must not relatch slot or mode.
        clear_log();
        pulse_start(4, 0);
        step(7);
        pulse_start(1, 1);
        wait_idle("busystart", 1000);
        step(2);
        chk("busystart_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("busystart_we", (i < wr_we.size()) ? wr_we[i] : 32'hDEAD, 32'b10000);
        chk("busystart_done", done_cnt, 1);

        // Reset during a WRITE cycle.
        pulse_start(0, 0);
        n = 0;
        while (!ram_wr && n < 1000) begin
            step();
            n++;
        end
        chk("rstwr_wait_timeout", 32'(n < 1000), 1);
        rst = 1'b1;
        #1;
        chk("rstwr_ram_wr", ram_wr, 0);
        chk("rstwr_slot_we", slot_we, 0);
        chk("rstwr_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        clear_log();
        pulse_start(1, 0);
        wait_idle("rstwr_rerun", 1000);
        step(2);
        chk("rstwr_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("rstwr_addr", (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD, i);

        // Random traffic: sporadic starts with any slot/mode, sporadic aborts, random mic bits.
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom % 40 == 0);
            slot  = SLOT_W'($urandom % 8);
            mode  = 1'($urandom);
            abort = ($urandom % 300 == 0);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
